// File: rtl/gcd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_arbiter
//  Description : Shares one GCD engine among NREQ requesters. Requests are
//                granted round-robin with one job in flight at a time. The
//                arbiter latches the winner's operands, pulses the engine
//                start, waits for done, then returns the result to the winner
//                with a one-cycle valid pulse.
//  Option      : GCD_ARB_ZERO_BYPASS_EN - when defined, a job with a zero
//                operand is answered directly (x|y) without using the engine.
//  Ports       : clk, clr       clock, synchronous active-high reset
//                req            per-requester request level
//                x_in, y_in     packed operands, requester i at [i*W +: W]
//                gnt            one-hot owner of the current job
//                rsp_vld        one-hot one-cycle result pulse
//                rsp_gcd        result, valid with rsp_vld
//                busy           high whenever the FSM is not idle
//                eng_go         engine start pulse
//                eng_x, eng_y   engine operands (held LAUNCH..WAIT)
//                eng_gcd        engine result
//                eng_done       engine completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] x_in,
   input  logic [NREQ*W-1:0] y_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_vld,
   output logic [W-1:0]      rsp_gcd,
   output logic              busy,
   output logic              eng_go,
   output logic [W-1:0]      eng_x,
   output logic [W-1:0]      eng_y,
   input  logic [W-1:0]      eng_gcd,
   input  logic              eng_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_idx;

   logic            w_any;
   logic            w_hi_found;
   logic [IW-1:0]   w_hi;
   logic [IW-1:0]   w_lo;
   logic [IW-1:0]   w_win;
   logic [NREQ-1:0] w_win_oh;
   logic [W-1:0]    w_x;
   logic [W-1:0]    w_y;

   // Round-robin pick: the lowest requester at or above the pointer wins;
   // if none, wrap around to the lowest requester overall. The loop runs
   // downward so the last hit written is the lowest index.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi       = '0;
      w_lo       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_lo = IW'(i);
            if (IW'(i) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi       = IW'(i);
            end
         end
      end
   end

   assign w_any    = |req;
   assign w_win    = w_hi_found ? w_hi : w_lo;
   assign w_win_oh = NREQ'(1) << w_win;

   // Winner's operands, selected with constant slices only.
   always_comb begin
      w_x = '0;
      w_y = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == IW'(i)) begin
            w_x = x_in[i*W +: W];
            w_y = y_in[i*W +: W];
         end
      end
   end

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         gnt     <= '0;
         rsp_vld <= '0;
         rsp_gcd <= '0;
         eng_go  <= 1'b0;
         eng_x   <= '0;
         eng_y   <= '0;
      end else begin
         // Pulsed outputs default low every cycle.
         eng_go  <= 1'b0;
         rsp_vld <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_idx <= w_win;
                  gnt   <= w_win_oh;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                  // gcd(0,y)=y, gcd(x,0)=x, gcd(0,0)=0: all equal x|y.
                  if ((w_x == '0) || (w_y == '0)) begin
                     rsp_vld <= w_win_oh;
                     rsp_gcd <= w_x | w_y;
                     r_state <= S_RESP;
                  end else
`endif
                  begin
                     eng_go  <= 1'b1;
                     eng_x   <= w_x;
                     eng_y   <= w_y;
                     r_state <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Only a done seen here belongs to the current job.
               if (eng_done) begin
                  eng_x   <= '0;
                  eng_y   <= '0;
                  rsp_vld <= gnt;
                  rsp_gcd <= eng_gcd;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               gnt     <= '0;
               rsp_gcd <= '0;
               r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
